// File: rtl/alu_pkg.sv
// Operation encodings shared by the 4-bit ripple ALU slice and its 1-bit cells.
package alu_pkg;

    localparam int unsigned ALU_W = 4;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SLT = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_1b.sv
// One ripple ALU cell: optional operand inversion, AND/OR/full-add/less select.
module alu_1b
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    less,
    input  logic    cin,
    input  logic    ainvert,
    input  logic    binvert,
    input  alu_op_e op,
    output logic    result,
    output logic    cout
);

    logic a_eff;
    logic b_eff;
    logic sum;

    always_comb begin
        a_eff  = ainvert ? ~a : a;
        b_eff  = binvert ? ~b : b;
        sum    = a_eff ^ b_eff ^ cin;
        // Carry is produced regardless of op so the chain always reflects the adder.
        cout   = (a_eff & b_eff) | (cin & (a_eff ^ b_eff));
        result = 1'b0;
        unique case (op)
            OP_AND: result = a_eff & b_eff;
            OP_OR:  result = a_eff | b_eff;
            OP_ADD: result = sum;
            OP_SLT: result = less;
        endcase
    end

endmodule

// File: rtl/alu_4b.sv
// Four-bit ALU slice built from four chained alu_1b cells; result and carry-out
// are registered once with an asynchronous active-low clear.
module alu_4b
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    output logic [ALU_W-1:0] Y,
    output logic             CarryOut,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic             Less,
    input  logic             CarryIn,
    input  logic             Ainvert,
    input  logic             Binvert,
    input  logic [1:0]       Op
);

    logic [ALU_W:0]   carry;
    logic [ALU_W-1:0] less_vec;
    logic [ALU_W-1:0] y_d;
    logic [ALU_W-1:0] y_q;
    logic             co_d;
    logic             co_q;
    alu_op_e          op_sel;

    assign carry[0] = CarryIn;
    // Only the LSB cell sees the set-less-than input; upper bits read zero.
    assign less_vec = {{(ALU_W-1){1'b0}}, Less};
    assign op_sel   = alu_op_e'(Op);

    genvar i;
    generate
        for (i = 0; i < ALU_W; i++) begin : g_cell
            alu_1b u_cell (
                .a       (A[i]),
                .b       (B[i]),
                .less    (less_vec[i]),
                .cin     (carry[i]),
                .ainvert (Ainvert),
                .binvert (Binvert),
                .op      (op_sel),
                .result  (y_d[i]),
                .cout    (carry[i+1])
            );
        end
    endgenerate

    assign co_d = carry[ALU_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q  <= '0;
            co_q <= 1'b0;
        end else begin
            y_q  <= y_d;
            co_q <= co_d;
        end
    end

    assign Y        = y_q;
    assign CarryOut = co_q;

endmodule

// File: tb/tb_alu_4b.sv
// Scoreboarded bench for alu_4b: directed vectors with hand-computed results.
module tb_alu_4b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A, B, Y;
    logic       Less, CarryIn, Ainvert, Binvert, CarryOut;
    logic [1:0] Op;

    typedef struct {
        string      name;
        logic [3:0] y;
        logic       co;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    logic issue = 1'b0;

    always #5 clk = ~clk;

    alu_4b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Y        (Y),
        .CarryOut (CarryOut),
        .A        (A),
        .B        (B),
        .Less     (Less),
        .CarryIn  (CarryIn),
        .Ainvert  (Ainvert),
        .Binvert  (Binvert),
        .Op       (Op)
    );

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: Y got %b want %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: CarryOut got %b want %b", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic less,
                          input logic cin, input logic ainv, input logic binv,
                          input logic [1:0] op);
        A = a; B = b; Less = less; CarryIn = cin;
        Ainvert = ainv; Binvert = binv; Op = op;
    endtask

    task automatic drive(input string name, input logic [3:0] a, input logic [3:0] b,
                         input logic less, input logic cin, input logic ainv,
                         input logic binv, input logic [1:0] op,
                         input logic [3:0] y, input logic co);
        exp_t e;
        @(negedge clk);
        set_in(a, b, less, cin, ainv, binv, op);
        e.name = name; e.y = y; e.co = co;
        sb_q.push_back(e);
        issue = 1'b1;
    endtask

    // Monitor: every edge that captured an issued vector yields one result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (issue && rst_n) begin
                #1;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_empty: got Y=%b with no expected entry", Y);
                end else begin
                    e = sb_q.pop_front();
                    check4(e.name, Y, e.y);
                    check1(e.name, CarryOut, e.co);
                end
            end
        end
    end

    initial begin
        int waited;
        set_in(4'b1111, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10);
        rst_n = 1'b0;
        #2;
        check4("reset_no_clock", Y, 4'b0000);
        check1("reset_no_clock", CarryOut, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check4("reset_held_edge", Y, 4'b0000);
        check1("reset_held_edge", CarryOut, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //     name          A        B        Less  Cin   Ainv  Binv  Op      Y        Co
        drive("and",        4'b1101, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1000, 1'b1);
        drive("or",         4'b1101, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'b1111, 1'b1);
        drive("add_c0",     4'b1101, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0111, 1'b1);
        drive("add_c1",     4'b1101, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 4'b1000, 1'b1);
        drive("sub",        4'b1101, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'b0011, 1'b1);
        drive("nor",        4'b0101, 4'b0010, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 4'b1000, 1'b1);
        drive("slt_l0",     4'b1101, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0000, 1'b1);
        drive("slt_l1",     4'b1101, 4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 4'b0001, 1'b1);
        drive("add_zero",   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0000, 1'b0);
        drive("add_small",  4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0100, 1'b0);
        drive("add_wrap",   4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b0000, 1'b1);
        drive("nand",       4'b1100, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 4'b0111, 1'b0);
        drive("sub_neg",    4'b0011, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 4'b1110, 1'b0);
        drive("and_ainv",   4'b0000, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'b0110, 1'b1);
        drive("or_binv",    4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 4'b0001, 1'b0);
        drive("slt_co0",    4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'b0001, 1'b0);
        @(negedge clk);
        issue = 1'b0;

        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending got %0d want 0", sb_q.size());
        end

        // Direct checks: load, hold between edges, mid-cycle reset, release.
        @(negedge clk);
        set_in(4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10);
        @(posedge clk);
        #1;
        check4("load_full", Y, 4'b1111);
        check1("load_full", CarryOut, 1'b1);
        #2;
        set_in(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        check4("hold_between_edges", Y, 4'b1111);
        check1("hold_between_edges", CarryOut, 1'b1);
        set_in(4'b0110, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        rst_n = 1'b0;
        #1;
        check4("reset_mid_cycle", Y, 4'b0000);
        check1("reset_mid_cycle", CarryOut, 1'b0);
        @(posedge clk);
        #1;
        check4("reset_discards_pending", Y, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check4("release_before_edge", Y, 4'b0000);
        @(posedge clk);
        #1;
        check4("first_after_release", Y, 4'b1001);
        check1("first_after_release", CarryOut, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
